sync_fifo_fwft: RTL and testbench

Single-clock, parametrised FIFO; the same-clock successor to async_fifo for paths where producer and consumer share one clock.
Adds the following, selectable by parameter:
- first-word-fall-through (FWFT) or standard read mode;
- programmable almost_full / almost_empty thresholds;
- occupancy count output;
- synchronous flush;
- sticky overflow / underflow error flags.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 115 +++++++++++
 tb/tb_sync_fifo_fwft.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the read-mode type for the single-clock FIFO family.
package fifo_pkg;

   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Pointers and the occupancy count carry one extra bit so DEPTH itself is representable.
   function automatic int fifo_cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read, threshold flags,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int         DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int         PW    = fifo_cnt_width(ADDR_WIDTH);
   localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_range
      $fatal(1, "sync_fifo_fwft: AF_LEVEL out of range 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_range
      $fatal(1, "sync_fifo_fwft: AE_LEVEL out of range 0..DEPTH-1");
   end

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  wr_fire, rd_fire;

   // Handshake: wr_en/rd_en are requests; a word transfers only at an edge where the request is
   // high, flush is low and the registered full (write) / empty (read) flag is low. A request
   // against full/empty is dropped and raises the matching sticky flag; flush drops both silently.
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign count = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   assign wr_fire = wr_en && !full  && !flush;
   assign rd_fire = rd_en && !empty && !flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      dout_d      = dout_q;
      // A fresh error in the same cycle as err_clr leaves the flag set.
      overflow_d  = (wr_en && full  && !flush) || (overflow_q  && !err_clr);
      underflow_d = (rd_en && empty && !flush) || (underflow_q && !err_clr);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dout_d   = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         dout_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         dout_q      <= dout_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // FWFT presents the head word combinationally and shows zero while empty.
   assign dout = (MODE == FIFO_FWFT) ? (empty ? '0 : mem_rdata) : dout_q;

   sync_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .clk  (clk),
      .we   (wr_fire),
      .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata(din),
      .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// against a queue-based reference model every cycle.
module tb_sync_fifo_fwft;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [AW:0]   count_s, count_f;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout_std = '0;
  bit            m_ovf = 0;
  bit            m_unf = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(count_s), .overflow(ovf_s), .underflow(unf_s), .err_clr(err_clr)
  );

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f), .err_clr(err_clr)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // advance the model across one edge using the inputs presented to it, then compare
  task automatic step();
    int sz;
    bit new_ovf, new_unf;
    logic [DW-1:0] head;
    @(posedge clk);
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      m_dout_std = '0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      new_ovf = !flush && wr_en && (sz == DEPTH);
      new_unf = !flush && rd_en && (sz == 0);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (rd_en && sz > 0) m_dout_std = exp_q.pop_front();
        if (wr_en && sz < DEPTH) exp_q.push_back(din);
      end
      m_ovf = new_ovf || (m_ovf && !err_clr);
      m_unf = new_unf || (m_unf && !err_clr);
    end
    #1;
    sz = exp_q.size();
    head = (sz > 0) ? exp_q[0] : '0;
    check_eq("count_s", DW'(count_s), DW'(sz));
    check_eq("count_f", DW'(count_f), DW'(sz));
    check_eq("full_s",  DW'(full_s),  DW'(sz == DEPTH));
    check_eq("full_f",  DW'(full_f),  DW'(sz == DEPTH));
    check_eq("empty_s", DW'(empty_s), DW'(sz == 0));
    check_eq("empty_f", DW'(empty_f), DW'(sz == 0));
    check_eq("af_s",    DW'(af_s),    DW'(sz >= AF));
    check_eq("af_f",    DW'(af_f),    DW'(sz >= AF));
    check_eq("ae_s",    DW'(ae_s),    DW'(sz <= AE));
    check_eq("ae_f",    DW'(ae_f),    DW'(sz <= AE));
    check_eq("ovf_s",   DW'(ovf_s),   DW'(m_ovf));
    check_eq("ovf_f",   DW'(ovf_f),   DW'(m_ovf));
    check_eq("unf_s",   DW'(unf_s),   DW'(m_unf));
    check_eq("unf_f",   DW'(unf_f),   DW'(m_unf));
    check_eq("dout_s",  dout_s,       m_dout_std);
    check_eq("dout_f",  dout_f,       head);
  endtask

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit fl = 0, input bit ec = 0, input bit rs = 0);
    @(negedge clk);
    wr_en = w; din = d; rd_en = r; flush = fl; err_clr = ec; rst = rs;
    step();
  endtask

  initial begin
    // reset
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);

    // fill to full, push 3 more (overflow), drain all 16, then read empty (underflow)
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h1A2B_0000 + DW'(i), 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hBAD0_0000 + DW'(i), 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0);

    // single word to empty FIFO, visible without rd_en in FWFT, then popped
    cyc(1, 32'hDEAD_BEEF, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 1);

    // streaming at steady count 8 across several wraps
    for (int i = 0; i < 8; i++) cyc(1, $urandom, 0);
    for (int i = 0; i < 64; i++) cyc(1, $urandom, 1);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1);

    // flush at count 10 with both requests high, then a fresh word
    for (int i = 0; i < 10; i++) cyc(1, $urandom, 0);
    cyc(1, 32'hFFFF_FFFF, 1, 1);
    cyc(1, 32'h0000_0055, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);

    // reset at count 7 with overflow set, then resume
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, $urandom, 0);
    for (int i = 0; i < 9; i++) cyc(0, '0, 1);
    cyc(1, $urandom, 1, 0, 0, 1);
    cyc(1, 32'h1234_5678, 0);
    cyc(0, '0, 1);

    // randomized traffic including err_clr racing new errors, flushes and resets
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, $urandom_range(0, 199) < 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
